// File: rtl/sprite_mem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the memory wrapper.
interface sprite_mem_arbiter_if;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 24;

    logic          Blank;
    logic          P0_Req;
    logic [AW-1:0] P0_Addr;
    logic          P0_Gnt;
    logic          P0_RValid;
    logic [DW-1:0] P0_RData;
    logic          P1_Req;
    logic [AW-1:0] P1_Addr;
    logic          P1_Gnt;
    logic          P1_RValid;
    logic [DW-1:0] P1_RData;
    logic          P2_Req;
    logic [AW-1:0] P2_Addr;
    logic [DW-1:0] P2_WData;
    logic          P2_Gnt;
    logic [AW-1:0] Mem_Addr;
    logic          Mem_WE;
    logic [DW-1:0] Mem_WData;
    logic [DW-1:0] Mem_RData;

    // Requesters plus memory wrapper side.
    modport master (
        output Blank, P0_Req, P0_Addr, P1_Req, P1_Addr,
               P2_Req, P2_Addr, P2_WData, Mem_RData,
        input  P0_Gnt, P0_RValid, P0_RData, P1_Gnt, P1_RValid, P1_RData,
               P2_Gnt, Mem_Addr, Mem_WE, Mem_WData
    );

    // Arbiter side.
    modport slave (
        input  Blank, P0_Req, P0_Addr, P1_Req, P1_Addr,
               P2_Req, P2_Addr, P2_WData, Mem_RData,
        output P0_Gnt, P0_RValid, P0_RData, P1_Gnt, P1_RValid, P1_RData,
               P2_Gnt, Mem_Addr, Mem_WE, Mem_WData
    );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// Three-port arbiter for the sprite/background memory: pixel fetch (P0),
// HUD reads (P1, starvation-protected) and blanking-time loader writes (P2).
module sprite_mem_arbiter #(
    parameter int unsigned LAT      = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_mem_arbiter_if.slave  bus
);
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 24;
    localparam int unsigned SW    = $clog2(MAX_WAIT + 1);
    localparam int unsigned DEPTH = LAT + 1;

    logic [2:0]       gnt;
    logic             force_p1;
    logic [SW-1:0]    starve;
    logic             rr;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [DW-1:0]    mem_wdata;
    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_port;

    // Grant selection for the current cycle; nothing is granted under reset.
    always_comb begin
        gnt      = 3'b000;
        force_p1 = (starve == SW'(MAX_WAIT));
        if (!Reset) begin
            if (!bus.Blank) begin
                if (force_p1 && bus.P1_Req) begin
                    gnt[1] = 1'b1;
                end else if (bus.P0_Req) begin
                    gnt[0] = 1'b1;
                end else if (bus.P1_Req) begin
                    gnt[1] = 1'b1;
                end
            end else begin
                if (bus.P0_Req) begin
                    gnt[0] = 1'b1;
                end else if (bus.P1_Req && bus.P2_Req) begin
                    if (rr) gnt[2] = 1'b1;
                    else    gnt[1] = 1'b1;
                end else if (bus.P1_Req) begin
                    gnt[1] = 1'b1;
                end else if (bus.P2_Req) begin
                    gnt[2] = 1'b1;
                end
            end
        end
    end

    // Count cycles P1 waits while requesting; saturate at the force threshold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            starve <= '0;
        end else if (!bus.P1_Req || gnt[1]) begin
            starve <= '0;
        end else if (starve != SW'(MAX_WAIT)) begin
            starve <= starve + SW'(1);
        end
    end

    // Round-robin preference between P1 and P2; 0 prefers P1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr <= 1'b0;
        end else if (gnt[1] || gnt[2]) begin
            rr <= ~rr;
        end
    end

    // Registered memory command for the granted access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= gnt[2];
            if (gnt[2]) mem_wdata <= bus.P2_WData;
            if (gnt[0])      mem_addr <= bus.P0_Addr;
            else if (gnt[1]) mem_addr <= bus.P1_Addr;
            else if (gnt[2]) mem_addr <= bus.P2_Addr;
        end
    end

    // Read tag pipeline: {valid, port} per grant, aligned with read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], gnt[0] | gnt[1]};
            tag_port  <= {tag_port[DEPTH-2:0], gnt[1]};
        end
    end

    assign bus.P0_Gnt    = gnt[0];
    assign bus.P1_Gnt    = gnt[1];
    assign bus.P2_Gnt    = gnt[2];
    assign bus.Mem_Addr  = mem_addr;
    assign bus.Mem_WE    = mem_we;
    assign bus.Mem_WData = mem_wdata;
    assign bus.P0_RData  = bus.Mem_RData;
    assign bus.P1_RData  = bus.Mem_RData;
    assign bus.P0_RValid = !Reset && tag_valid[LAT] && !tag_port[LAT];
    assign bus.P1_RValid = !Reset && tag_valid[LAT] &&  tag_port[LAT];
endmodule
